// File: rtl/heartbeat_monitor.sv
// rtl/heartbeat_monitor.sv - heartbeat period checker with alive/too-fast/lost status
module heartbeat_monitor #(
  parameter int CNT_W      = 30,
  parameter int MIN_PERIOD = 1000,
  parameter int TIMEOUT    = 2**29,
  parameter int LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hb_in,
  input  logic             clear_i,
  output logic             alive,
  output logic             lost,
  output logic             too_fast,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_LOCKING = 2'd1,
    S_ALIVE   = 2'd2,
    S_LOST    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [2:0]       LOCK_C    = 3'(LOCK_COUNT);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [1:0]       good_q, good_d;
  logic             alive_q, alive_d;
  logic             lost_q, lost_d;
  logic             too_fast_q, too_fast_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;

  logic             rise, good_edge, fast_edge, timeout, tracking;
  logic [CNT_W-1:0] meas;
  logic [2:0]       good_inc;

  assign rise      = sync2_q & ~prev_q;
  assign meas      = cnt_q + 1'b1;
  assign good_edge = rise && (meas >= MIN_C);
  assign fast_edge = rise && (meas < MIN_C);
  assign timeout   = !rise && (cnt_q == TIMEOUT_C);
  assign tracking  = (state_q == S_LOCKING) || (state_q == S_ALIVE);
  assign good_inc  = {1'b0, good_q} + 3'd1;

  // Counter saturates so a long-dead source never wraps back into a false timeout.
  always_comb begin
    if (rise)
      cnt_d = '0;
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      state_q    <= S_SEARCH;
      good_q     <= 2'd0;
      alive_q    <= 1'b0;
      lost_q     <= 1'b0;
      too_fast_q <= 1'b0;
      period_q   <= '0;
      pv_q       <= 1'b0;
    end else begin
      sync1_q    <= hb_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      good_q     <= good_d;
      alive_q    <= alive_d;
      lost_q     <= lost_d;
      too_fast_q <= too_fast_d;
      period_q   <= period_d;
      pv_q       <= pv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      S_SEARCH: begin
        if (rise) begin
          state_d = S_LOCKING;
          good_d  = 2'd0;
        end else if (timeout) begin
          state_d = S_LOST;
        end
      end
      S_LOCKING: begin
        if (good_edge) begin
          good_d = good_inc[1:0];
          if (good_inc == LOCK_C)
            state_d = S_ALIVE;
        end else if (fast_edge) begin
          good_d = 2'd0;
        end else if (timeout) begin
          state_d = S_LOST;
        end
      end
      S_ALIVE: begin
        if (fast_edge) begin
          state_d = S_LOCKING;
          good_d  = 2'd0;
        end else if (timeout) begin
          state_d = S_LOST;
        end
      end
      S_LOST: begin
        if (rise) begin
          state_d = S_LOCKING;
          good_d  = 2'd0;
        end
      end
      default: begin
        state_d = S_SEARCH;
        good_d  = 2'd0;
      end
    endcase
  end

  // A flag set in the same cycle as clear_i takes priority over the clear.
  always_comb begin
    alive_d    = (state_d == S_ALIVE);
    pv_d       = rise && tracking;
    period_d   = pv_d ? meas : period_q;
    lost_d     = lost_q;
    too_fast_d = too_fast_q;
    if (clear_i) begin
      lost_d     = 1'b0;
      too_fast_d = 1'b0;
    end
    if (timeout && (state_q != S_LOST))
      lost_d = 1'b1;
    if (fast_edge && tracking)
      too_fast_d = 1'b1;
  end

  assign alive        = alive_q;
  assign lost         = lost_q;
  assign too_fast     = too_fast_q;
  assign period       = period_q;
  assign period_valid = pv_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// tb/tb_heartbeat_monitor.sv - directed-vector bench for heartbeat_monitor
module tb_heartbeat_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hb_in = 1'b0;
  logic       clear_i = 1'b0;
  logic       alive, lost, too_fast, period_valid;
  logic [7:0] period;

  int vectors = 0;
  int miscompares = 0;
  int pv_cnt = 0;
  int base = 0;

  heartbeat_monitor #(
    .CNT_W(8), .MIN_PERIOD(4), .TIMEOUT(20), .LOCK_COUNT(3)
  ) dut (
    .clk(clk), .rst(rst), .hb_in(hb_in), .clear_i(clear_i),
    .alive(alive), .lost(lost), .too_fast(too_fast),
    .period(period), .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  // Counts high cycles of period_valid, so a stretched pulse is visible.
  always @(negedge clk) if (period_valid === 1'b1) pv_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hb_period(input int hi, input int lo);
    hb_in = 1'b1;
    repeat (hi) tick();
    hb_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alive"}, 32'(alive), 0);
    check({tag, "_lost"}, 32'(lost), 0);
    check({tag, "_too_fast"}, 32'(too_fast), 0);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_pv"}, 32'(period_valid), 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    hb_in = 1'b0;
    clear_i = 1'b0;
    repeat (3) tick();
    check_all_zero(tag);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    // Lock
    do_reset("reset0");
    base = pv_cnt;
    repeat (3) hb_period(5, 5);
    check("lock_alive_after3", 32'(alive), 0);
    check("lock_pv_after3", pv_cnt - base, 2);
    check("lock_period", 32'(period), 10);
    hb_period(5, 5);
    check("lock_alive_after4", 32'(alive), 1);
    check("lock_pv_after4", pv_cnt - base, 3);
    check("lock_lost", 32'(lost), 0);
    check("lock_too_fast", 32'(too_fast), 0);

    // Glitch: one 2-cycle period while alive
    hb_period(1, 1);
    hb_period(5, 5);
    check("glitch_period", 32'(period), 2);
    check("glitch_too_fast", 32'(too_fast), 1);
    check("glitch_alive", 32'(alive), 0);
    check("glitch_pv", pv_cnt - base, 5);
    repeat (2) hb_period(5, 5);
    check("relock_alive_after2", 32'(alive), 0);
    hb_period(5, 5);
    check("relock_alive_after3", 32'(alive), 1);
    check("relock_period", 32'(period), 10);
    check("relock_pv", pv_cnt - base, 8);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_too_fast", 32'(too_fast), 0);
    check("clear_period_holds", 32'(period), 10);

    // Loss: last rise started 11 edges ago; lost must appear 24 edges after hb rose
    repeat (12) tick();
    check("loss_edge20_alive", 32'(alive), 1);
    check("loss_edge20_lost", 32'(lost), 0);
    tick();
    check("loss_edge21_alive", 32'(alive), 0);
    check("loss_edge21_lost", 32'(lost), 1);
    repeat (3) hb_period(5, 5);
    check("resume_alive_after3", 32'(alive), 0);
    hb_period(5, 5);
    check("resume_alive_after4", 32'(alive), 1);
    check("resume_lost_sticky", 32'(lost), 1);
    check("resume_pv", pv_cnt - base, 11);

    // No source plus simultaneous clear in the timeout cycle
    do_reset("reset1");
    base = pv_cnt;
    repeat (20) tick();
    check("nosrc_edge20_lost", 32'(lost), 0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("simclear_set_wins", 32'(lost), 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_lost", 32'(lost), 0);
    repeat (300) tick();
    check("lost_stays_clear", 32'(lost), 0);
    check("nosrc_no_pv", pv_cnt - base, 0);
    hb_period(5, 5);
    check("from_lost_no_pv", pv_cnt - base, 0);
    check("from_lost_alive", 32'(alive), 0);
    repeat (3) hb_period(5, 5);
    check("from_lost_alive_after4", 32'(alive), 1);
    check("from_lost_pv", pv_cnt - base, 3);

    // Reset mid-lock with good=2
    do_reset("reset2");
    repeat (3) hb_period(5, 5);
    check("midlock_alive", 32'(alive), 0);
    check("midlock_period", 32'(period), 10);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick();
    rst = 1'b0;
    repeat (3) hb_period(5, 5);
    check("post_reset_alive_after3", 32'(alive), 0);
    hb_period(5, 5);
    check("post_reset_alive_after4", 32'(alive), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
